// File: rtl/rr_3req_pkg.sv
// Shared constants and grant-index type for the 3-port round-robin arbiter.
// Also used by the bus interleaver that instantiates it.
package rr_3req_pkg;

  localparam int NUM_REQ = 3;
  localparam int GRANT_W = 2;

  typedef logic [GRANT_W-1:0] grant_idx_t;

endpackage

// File: rtl/rr_3req.sv
// Three-requester round-robin arbiter with registered grant index.
// The search starts after the current holder; ce gates every update.
module rr_3req
  import rr_3req_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       request0,
  input  logic       request1,
  input  logic       request2,
  input  logic       ce,
  output grant_idx_t grant
);

  logic [NUM_REQ-1:0] req;
  grant_idx_t         grant_nxt;

  assign req = {request2, request1, request0};

  // The holder's own request is never a candidate; it only keeps the grant by default
  always_comb begin
    grant_nxt = grant;
    unique case (grant)
      2'd0: begin
        if (req[1])      grant_nxt = 2'd1;
        else if (req[2]) grant_nxt = 2'd2;
      end
      2'd1: begin
        if (req[2])      grant_nxt = 2'd2;
        else if (req[0]) grant_nxt = 2'd0;
      end
      2'd2: begin
        if (req[0])      grant_nxt = 2'd0;
        else if (req[1]) grant_nxt = 2'd1;
      end
      default: begin
        if (req[0])      grant_nxt = 2'd0;
        else if (req[1]) grant_nxt = 2'd1;
        else if (req[2]) grant_nxt = 2'd2;
        else             grant_nxt = 2'd0;
      end
    endcase
  end

  // rst_n is an active-high synchronous reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      grant <= '0;
    end else if (ce) begin
      grant <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_rr_3req.sv
// Directed bench for rr_3req: a table of sequential vectors
// plus hand-written latency and reset-priority sequences.
module tb_rr_3req;
  import rr_3req_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       request0;
  logic       request1;
  logic       request2;
  logic       ce;
  grant_idx_t grant;

  int errors;
  int checks;

  typedef struct {
    logic       rst;
    logic       ce;
    logic [2:0] req;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  rr_3req dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .request0 (request0),
    .request1 (request1),
    .request2 (request2),
    .ce       (ce),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic c,
                     input logic [2:0] q, input logic [1:0] e);
    vecs[nvec].rst = r;
    vecs[nvec].ce  = c;
    vecs[nvec].req = q;
    vecs[nvec].exp = e;
    nvec++;
  endtask

  task automatic drive(input logic r, input logic c, input logic [2:0] q);
    rst_n    = r;
    ce       = c;
    request0 = q[0];
    request1 = q[1];
    request2 = q[2];
  endtask

  task automatic check(input string name, input logic [1:0] exp);
    checks++;
    if (grant !== exp) begin
      errors++;
      $display("FAIL %s: grant=%0d expected=%0d", name, grant, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic c, input logic [2:0] q,
                      input logic [1:0] exp, input string name);
    @(negedge clk);
    drive(r, c, q);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    nvec   = 0;
    drive(1'b1, 1'b0, 3'b000);

    // Reset, then hold with ce=0 under full request load
    add(1, 0, 3'b000, 0);
    add(1, 0, 3'b111, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 3'b111, 0);
    // Rotation with everybody requesting
    add(0, 1, 3'b111, 1);
    add(0, 1, 3'b111, 2);
    add(0, 1, 3'b111, 0);
    add(0, 1, 3'b111, 1);
    // Idle enable has no effect
    add(0, 1, 3'b000, 1);
    // Skip from 0 to 2, then to 1
    add(1, 0, 3'b000, 0);
    add(0, 1, 3'b100, 2);
    add(0, 1, 3'b010, 1);
    // Holder alone keeps grant, with or without own request
    add(0, 1, 3'b010, 1);
    add(0, 1, 3'b000, 1);
    // ce=0 freezes grant
    add(0, 0, 3'b111, 1);
    add(0, 0, 3'b101, 1);
    // Holder request does not block; rotation order from each holder
    add(0, 1, 3'b101, 2);
    add(0, 1, 3'b011, 0);
    add(0, 1, 3'b101, 2);
    add(0, 1, 3'b110, 1);
    add(0, 1, 3'b011, 0);
    add(0, 1, 3'b101, 2);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].req, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Latency: grant=2 now; one ce pulse with only request0
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b001);
    #1;
    check("no_comb_path", 2'd2);
    @(posedge clk);
    #1;
    check("latency_1cyc", 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b111, 2'd0, $sformatf("hold_after_pulse%0d", i));
    end

    // Reset priority over ce and requests, then arbitration from 0
    step(1'b0, 1'b1, 3'b010, 2'd1, "pre_rst_grant1");
    step(1'b1, 1'b1, 3'b010, 2'd0, "rst_priority");
    step(1'b1, 1'b1, 3'b100, 2'd0, "rst_priority2");
    step(1'b0, 1'b1, 3'b110, 2'd1, "post_rst_from0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_3req.md
RR_3REQ -- requirements
Module: rr_3req

Interface
REQ-001 Parameters: none; the requester count (3) and the grant width (2) are fixed.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset. Synchronous and active-high: reset is asserted when rst_n=1 and is sampled on the clk rising edge. The port name matches the codebase.
REQ-004 request0  input  1  Request from port 0.
REQ-005 request1  input  1  Request from port 1.
REQ-006 request2  input  1  Request from port 2.
REQ-007 ce  input  1  Arbitration enable; the grant may change only on cycles where ce=1.
REQ-008 grant  output  2  Index of the currently granted port (0, 1 or 2); registered output.

Function
REQ-009 grant SHALL be a register driven directly to the output, with no combinational path from inputs to grant.
REQ-010 When ce=0, grant SHALL hold its value regardless of the request inputs.
REQ-011 When ce=1 and current grant=g, the block SHALL search in round-robin order starting after g:
- first candidate (g+1) mod 3;
- second candidate (g+2) mod 3;
- the first candidate whose request is 1 SHALL be loaded into grant on that edge.
REQ-012 When ce=1 and neither other port requests, grant SHALL keep g; this applies whether or not port g itself requests.
REQ-013 The current holder's own request SHALL never block rotation: if g and any other port both request with ce=1, grant moves to the other port.
REQ-014 Latency: the new grant SHALL be visible on the cycle after the ce=1 edge (1-cycle latency).
REQ-015 All requests=0 with ce=1: grant unchanged.
REQ-016 Simultaneous requests: selection is by the rotation order of REQ-011 only; there is no fixed priority.
REQ-017 grant SHALL never take the value 3. If grant is 3 anyway (illegal state), the next ce=1 edge SHALL evaluate candidates in the order 0, 1, 2, and SHALL load 0 if no port requests.
REQ-018 ce=1 while all request inputs are 0 is legal and SHALL have no side effects.

Reset
REQ-019 While rst_n=1 at a clk edge, grant SHALL load 0. Reset has priority over ce and the request inputs.
REQ-020 Reset asserted mid-arbitration SHALL abort any pending update; the first edge after reset release arbitrates from grant=0.
REQ-021 There SHALL be no other state; grant is the only storage element.

Structure
REQ-022 The shared package SHALL hold:
- constant NUM_REQ=3;
- constant GRANT_W=2;
- a grant-index typedef (2-bit) reused by the bus interleaver that instantiates this block.
REQ-023 The block SHALL be a single flat module with no sub-modules. The next-grant logic SHALL be a combinational function of (grant, request0..2), followed by one register stage.

Verification
REQ-024 Reset check: rst_n=1 for 2 cycles, then 0 -> grant=0. With ce=0 and all requests=1 for 5 cycles -> grant stays 0.
REQ-025 Rotation: from grant=0, all requests=1, ce=1 for 4 consecutive cycles -> grant sequence 1, 2, 0, 1.
REQ-026 Skip: grant=0, request0=0, request1=0, request2=1, ce=1 -> grant=2. Then only request1=1, ce=1 -> grant=1.
REQ-027 No other requester: grant=1, only request1=1, ce=1 -> grant stays 1. Then all requests=0, ce=1 -> grant stays 1.
REQ-028 Latency and reset priority:
- grant=2, request0=1 only, ce pulsed for 1 cycle -> grant=0 exactly one cycle later and holds afterwards;
- rst_n=1 coinciding with ce=1 and request1=1 -> grant=0.
